// File: rtl/pipe_front_regs_pkg.sv
// Shared pipeline-front definitions: FSM state encoding and the default squash instruction.
package pipe_front_regs_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_FLUSH = 2'b10
  } pipe_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pipe_front_regs_sat_counter.sv
// Event counter that sticks at all-ones; one cycle from inc_i to cnt_o, no backpressure.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_front_regs.sv
// PC, IF/ID and ID/EX control registers with stall/bubble/flush; one cycle per stage, held by gated stalls.
// Optional PIPE_STALL_CNT_EN adds saturating stall_cnt/flush_cnt outputs.
module pipe_front_regs
  import pipe_front_regs_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CTRL_W    = 8,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              PCwrite,
  input  logic              IF_IDwrite,
  input  logic              control_sel,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       instr_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  output logic [31:0]       pc_out,
  output logic [31:0]       if_id_pc,
  output logic [31:0]       if_id_instr,
  output logic              if_id_valid,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic              id_ex_valid,
  output logic [1:0]        pipe_state
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       if_id_pc_q, if_id_pc_d;
  logic [31:0]       if_id_instr_q, if_id_instr_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [CTRL_W-1:0] id_ex_ctrl_q, id_ex_ctrl_d;
  logic              id_ex_valid_q, id_ex_valid_d;
  pipe_state_e       state_q, state_d;

  // A squashed IF/ID entry has nothing to protect, so it never holds or bubbles.
  logic hold_pc, hold_if_id, bubble;
  assign hold_pc    = if_id_valid_q & ~PCwrite;
  assign hold_if_id = if_id_valid_q & ~IF_IDwrite;
  assign bubble     = if_id_valid_q & control_sel;

  always_comb begin
    pc_d          = pc_q + PC_STEP;
    if_id_pc_d    = pc_q;
    if_id_instr_d = instr_in;
    if_id_valid_d = 1'b1;
    id_ex_ctrl_d  = ctrl_in;
    id_ex_valid_d = if_id_valid_q;
    state_d       = ST_RUN;
    if (branch_taken) begin
      pc_d          = branch_target;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
      id_ex_ctrl_d  = '0;
      id_ex_valid_d = 1'b0;
      state_d       = ST_FLUSH;
    end else begin
      if (hold_pc) begin
        pc_d = pc_q;
      end
      if (hold_if_id) begin
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
      end
      if (bubble) begin
        id_ex_ctrl_d  = '0;
        id_ex_valid_d = 1'b0;
      end
      if (hold_pc || hold_if_id || bubble) begin
        state_d = ST_STALL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      id_ex_ctrl_q  <= '0;
      id_ex_valid_q <= 1'b0;
      state_q       <= ST_RUN;
    end else begin
      pc_q          <= pc_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
      id_ex_ctrl_q  <= id_ex_ctrl_d;
      id_ex_valid_q <= id_ex_valid_d;
      state_q       <= state_d;
    end
  end

  assign pc_out      = pc_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_valid = if_id_valid_q;
  assign id_ex_ctrl  = id_ex_ctrl_q;
  assign id_ex_valid = id_ex_valid_q;
  assign pipe_state  = state_q;

`ifdef PIPE_STALL_CNT_EN
  // Counts follow the state being entered, so they line up with pipe_state a cycle later.
  sat_counter #(.W(32)) u_stall_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc_i  (state_d == ST_STALL),
    .cnt_o  (stall_cnt)
  );

  sat_counter #(.W(32)) u_flush_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc_i  (state_d == ST_FLUSH),
    .cnt_o  (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_front_regs.sv
// Directed table-driven bench for pipe_front_regs built with RESET_PC = 0x100.
module tb_pipe_front_regs;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        PCwrite, IF_IDwrite, control_sel, branch_taken;
  logic [31:0] branch_target, instr_in;
  logic [7:0]  ctrl_in;
  logic [31:0] pc_out, if_id_pc, if_id_instr;
  logic        if_id_valid, id_ex_valid;
  logic [7:0]  id_ex_ctrl;
  logic [1:0]  pipe_state;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  pipe_front_regs #(
    .RESET_PC (32'h0000_0100),
    .CTRL_W   (8),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .PCwrite      (PCwrite),
    .IF_IDwrite   (IF_IDwrite),
    .control_sel  (control_sel),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr_in     (instr_in),
    .ctrl_in      (ctrl_in),
    .pc_out       (pc_out),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .id_ex_ctrl   (id_ex_ctrl),
    .id_ex_valid  (id_ex_valid),
    .pipe_state   (pipe_state)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  typedef struct {
    logic        pcw, ifw, csel, br;
    logic [31:0] tgt, instr;
    logic [7:0]  ctrl;
    logic [31:0] e_pc, e_ipc, e_iinstr;
    logic        e_iv;
    logic [7:0]  e_ctrl;
    logic        e_ev;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vt[15];

  task automatic drive(input logic pcw, input logic ifw, input logic csel, input logic br,
                       input logic [31:0] tgt, input logic [31:0] instr, input logic [7:0] ctrl);
    PCwrite       = pcw;
    IF_IDwrite    = ifw;
    control_sel   = csel;
    branch_taken  = br;
    branch_target = tgt;
    instr_in      = instr;
    ctrl_in       = ctrl;
  endtask

  task automatic check(input string name, input logic [31:0] e_pc, input logic [31:0] e_ipc,
                       input logic [31:0] e_iinstr, input logic e_iv, input logic [7:0] e_ctrl,
                       input logic e_ev, input logic [1:0] e_st);
    n_vec++;
    if ({pc_out, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl, id_ex_valid, pipe_state} !==
        {e_pc, e_ipc, e_iinstr, e_iv, e_ctrl, e_ev, e_st}) begin
      n_miss++;
      $display("FAIL %s: got pc=%h ifid=%h/%h/%b idex=%h/%b st=%b, want pc=%h ifid=%h/%h/%b idex=%h/%b st=%b",
               name, pc_out, if_id_pc, if_id_instr, if_id_valid, id_ex_ctrl, id_ex_valid, pipe_state,
               e_pc, e_ipc, e_iinstr, e_iv, e_ctrl, e_ev, e_st);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //         pcw ifw csel br  target        instr         ctrl    pc            if_id_pc      if_id_instr   iv ctrl   ev  state
    vt[0]  = '{1, 1, 0, 0, 32'h0,         32'h0000_1111, 8'h11, 32'h104,      32'h100,      32'h0000_1111, 1, 8'h11, 0, 2'b00};
    vt[1]  = '{1, 1, 0, 0, 32'h0,         32'h0000_2222, 8'h22, 32'h108,      32'h104,      32'h0000_2222, 1, 8'h22, 1, 2'b00};
    vt[2]  = '{1, 1, 0, 0, 32'h0,         32'h0000_000A, 8'h33, 32'h10C,      32'h108,      32'h0000_000A, 1, 8'h33, 1, 2'b00};
    vt[3]  = '{0, 0, 1, 0, 32'h0,         32'h0000_4444, 8'h44, 32'h10C,      32'h108,      32'h0000_000A, 1, 8'h00, 0, 2'b01};
    vt[4]  = '{1, 1, 0, 0, 32'h0,         32'h0000_5555, 8'h55, 32'h110,      32'h10C,      32'h0000_5555, 1, 8'h55, 1, 2'b00};
    vt[5]  = '{0, 1, 0, 0, 32'h0,         32'h0000_6666, 8'h66, 32'h110,      32'h110,      32'h0000_6666, 1, 8'h66, 1, 2'b01};
    vt[6]  = '{1, 0, 0, 0, 32'h0,         32'h0000_7777, 8'h77, 32'h114,      32'h110,      32'h0000_6666, 1, 8'h77, 1, 2'b01};
    vt[7]  = '{0, 0, 1, 1, 32'h200,       32'h0000_8888, 8'h88, 32'h200,      32'h114,      32'h0000_0013, 0, 8'h00, 0, 2'b10};
    vt[8]  = '{0, 0, 1, 0, 32'h0,         32'h0000_9999, 8'h99, 32'h204,      32'h200,      32'h0000_9999, 1, 8'h99, 0, 2'b00};
    vt[9]  = '{1, 1, 0, 1, 32'hFFFF_FFFC, 32'h0000_AAAA, 8'hAA, 32'hFFFF_FFFC, 32'h204,      32'h0000_0013, 0, 8'h00, 0, 2'b10};
    vt[10] = '{1, 1, 0, 0, 32'h0,         32'h0000_BBBB, 8'hBB, 32'h0,        32'hFFFF_FFFC, 32'h0000_BBBB, 1, 8'hBB, 0, 2'b00};
    vt[11] = '{1, 1, 0, 1, 32'h300,       32'h0000_CCCC, 8'hCC, 32'h300,      32'h0,        32'h0000_0013, 0, 8'h00, 0, 2'b10};
    vt[12] = '{1, 1, 0, 1, 32'h400,       32'h0000_DDDD, 8'hDD, 32'h400,      32'h300,      32'h0000_0013, 0, 8'h00, 0, 2'b10};
    vt[13] = '{1, 1, 0, 0, 32'h0,         32'h0000_EEEE, 8'hEE, 32'h404,      32'h400,      32'h0000_EEEE, 1, 8'hEE, 0, 2'b00};
    vt[14] = '{1, 1, 1, 0, 32'h0,         32'h0000_F0F0, 8'hF0, 32'h408,      32'h404,      32'h0000_F0F0, 1, 8'h00, 0, 2'b01};

    // Reset with a branch and stall pending: reset must win.
    reset_n = 1'b0;
    drive(0, 0, 1, 1, 32'h0000_0500, 32'h0000_DEAD, 8'hFF);
    tick();
    check("reset", 32'h100, 32'h0, 32'h13, 1'b0, 8'h00, 1'b0, 2'b00);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vt[i].pcw, vt[i].ifw, vt[i].csel, vt[i].br, vt[i].tgt, vt[i].instr, vt[i].ctrl);
      tick();
      check($sformatf("vec%0d", i), vt[i].e_pc, vt[i].e_ipc, vt[i].e_iinstr, vt[i].e_iv,
            vt[i].e_ctrl, vt[i].e_ev, vt[i].e_st);
    end

    // Long stall: PC and IF/ID must survive every cycle, ID/EX keeps loading.
    for (int c = 0; c < 5; c++) begin
      drive(0, 0, 0, 0, 32'h0, 32'h0000_1234 + c, 8'h5A);
      tick();
      check($sformatf("stall%0d", c), 32'h408, 32'h404, 32'h0000_F0F0, 1'b1, 8'h5A, 1'b1, 2'b01);
    end

    // Reset in the middle of the stall, again with a branch present.
    reset_n = 1'b0;
    drive(0, 0, 1, 1, 32'h0000_0600, 32'h0000_BEEF, 8'h77);
    tick();
    check("reset_mid_stall", 32'h100, 32'h0, 32'h13, 1'b0, 8'h00, 1'b0, 2'b00);
`ifdef PIPE_STALL_CNT_EN
    n_vec++;
    if (stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin
      n_miss++;
      $display("FAIL cnt_reset: got stall=%h flush=%h, want 0/0", stall_cnt, flush_cnt);
    end
`endif
    reset_n = 1'b1;

    // Reset in the middle of a flush.
    drive(1, 1, 0, 1, 32'h0000_0700, 32'h0000_0001, 8'h01);
    tick();
    check("flush_after_reset", 32'h700, 32'h100, 32'h13, 1'b0, 8'h00, 1'b0, 2'b10);
    reset_n = 1'b0;
    drive(0, 0, 1, 1, 32'h0000_0800, 32'h0000_0002, 8'h02);
    tick();
    check("reset_mid_flush", 32'h100, 32'h0, 32'h13, 1'b0, 8'h00, 1'b0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
